multicycle_controller: RTL and testbench

Sequencing FSM for the 16-bit multi-cycle processor. It decodes the instruction opcode and, state by state, drives the `Calculations` datapath selects (ALUOp, ALUSrcA/B, PCSrc) together with the PC, IR, memory and register-file strobes. Memory accesses use a ready handshake. A retired-instruction counter is provided for debug.

---
 rtl/multicycle_controller_pkg.sv | 58 +++++
 rtl/ctrl_decode.sv | 63 ++++++
 rtl/multicycle_controller.sv | 98 +++++++++
 tb/tb_multicycle_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// cpu_defs: shared opcode, ALU, select and state encodings for the multi-cycle CPU.
package cpu_defs;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_BLT  = 4'h8;
    localparam logic [3:0] OP_JUMP = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_IDLE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;

    localparam logic [1:0] SRCA_A    = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;
    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_TWO  = 2'b10;
    localparam logic       PCSRC_ALU    = 1'b0;
    localparam logic       PCSRC_ALUOUT = 1'b1;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       pc_src;
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational state/opcode/flag lookup producing the datapath control word.
module ctrl_decode
    import cpu_defs::*;
(
    input  state_t     i_state,
    input  logic [3:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_negative,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read = 1'b1;
                if (i_mem_ready) begin
                    o_ctrl.ir_write = 1'b1;
                    o_ctrl.pc_write = 1'b1;
                    o_ctrl.src_a    = SRCA_PC;
                    o_ctrl.src_b    = SRCB_TWO;
                    o_ctrl.alu_op   = ALU_ADD;
                    o_ctrl.pc_src   = PCSRC_ALU;
                end
            end
            S_DECODE: begin
                o_ctrl.src_a  = SRCA_PC;
                o_ctrl.src_b  = SRCB_IMM;
                o_ctrl.alu_op = ALU_ADD;
            end
            S_EXEC_R: o_ctrl.alu_op = (i_opcode == OP_SUB) ? ALU_SUB :
                                      (i_opcode == OP_AND) ? ALU_AND :
                                      (i_opcode == OP_OR)  ? ALU_OR  : ALU_ADD;
            S_EXEC_I, S_MEM_ADDR: begin
                o_ctrl.src_b  = SRCB_IMM;
                o_ctrl.alu_op = ALU_ADD;
            end
            S_ALU_WB: o_ctrl.reg_write = 1'b1;
            S_MEM_RD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_op   = ALU_SUB;
                o_ctrl.pc_src   = PCSRC_ALUOUT;
                o_ctrl.pc_write = (i_opcode == OP_BLT) ? i_negative : i_zero;
            end
            S_JUMP: begin
                o_ctrl.pc_src   = PCSRC_ALUOUT;
                o_ctrl.pc_write = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM for the 16-bit multi-cycle CPU with
// memory-wait timeout and retired-instruction counter.
module multicycle_controller
    import cpu_defs::*;
#(
    parameter int WAIT_LIMIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  input_opcode,
    input  logic        input_Zero,
    input  logic        input_negative,
    input  logic        input_mem_ready,
    output logic [2:0]  output_ALUOp,
    output logic [1:0]  output_ALUSrcA,
    output logic [1:0]  output_ALUSrcB,
    output logic        output_PCSrc,
    output logic        output_PCWrite,
    output logic        output_IRWrite,
    output logic        output_IorD,
    output logic        output_MemRead,
    output logic        output_MemWrite,
    output logic        output_RegWrite,
    output logic        output_MemToReg,
    output logic        output_halted,
    output logic [3:0]  output_state,
    output logic [15:0] output_instr_count
);
    state_t      r_state, w_next;
    logic [15:0] r_count, r_wait;
    logic        w_waiting, w_timeout;
    ctrl_t       w_ctrl, w_out;

    ctrl_decode u_decode (
        .i_state    (r_state),
        .i_opcode   (input_opcode),
        .i_zero     (input_Zero),
        .i_negative (input_negative),
        .i_mem_ready(input_mem_ready),
        .o_ctrl     (w_ctrl)
    );

    assign w_waiting = (r_state inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !input_mem_ready;
    assign w_timeout = (WAIT_LIMIT > 0) && w_waiting && (int'(r_wait) == WAIT_LIMIT - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = input_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: case (input_opcode)
                OP_ADD, OP_SUB, OP_AND, OP_OR: w_next = S_EXEC_R;
                OP_ADDI:        w_next = S_EXEC_I;
                OP_LW, OP_SW:   w_next = S_MEM_ADDR;
                OP_BEQ, OP_BLT: w_next = S_BRANCH;
                OP_JUMP:        w_next = S_JUMP;
                OP_HALT:        w_next = S_HALT;
                default:        w_next = S_FETCH;
            endcase
            S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
            S_MEM_ADDR: w_next = (input_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next = input_mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   w_next = input_mem_ready ? S_FETCH : S_MEM_WR;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_FETCH;
        endcase
        if (w_timeout) w_next = S_HALT;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_count <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_waiting && !w_timeout) ? r_wait + 16'd1 : '0;
            if (w_next == S_FETCH && r_state != S_FETCH) r_count <= r_count + 16'd1;
        end
    end

    // Reset masks every output combinationally so an aborted access emits no strobe.
    assign w_out              = reset ? w_ctrl : '0;
    assign output_ALUOp       = w_out.alu_op;
    assign output_ALUSrcA     = w_out.src_a;
    assign output_ALUSrcB     = w_out.src_b;
    assign output_PCSrc       = w_out.pc_src;
    assign output_PCWrite     = w_out.pc_write;
    assign output_IRWrite     = w_out.ir_write;
    assign output_IorD        = w_out.iord;
    assign output_MemRead     = w_out.mem_read;
    assign output_MemWrite    = w_out.mem_write;
    assign output_RegWrite    = w_out.reg_write;
    assign output_MemToReg    = w_out.mem_to_reg;
    assign output_halted      = reset && (r_state == S_HALT);
    assign output_state       = reset ? r_state : 4'd0;
    assign output_instr_count = reset ? r_count : 16'd0;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle vectors pushed to a scoreboard queue,
// checked by an independent negedge monitor against two DUTs (unlimited and WAIT_LIMIT=4).
module tb_multicycle_controller;
    typedef struct packed {
        logic [3:0] st;
        logic [2:0] alu;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [7:0] f;
        logic       h;
    } ctl_t;

    typedef struct packed {
        ctl_t        c;
        logic [15:0] cnt;
        logic [3:0]  st2;
    } exp_t;

    // f = {PCSrc, PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemToReg}
    localparam ctl_t E_RST  = '{4'd0,  3'd0, 2'd0, 2'd0, 8'b00000000, 1'b0};
    localparam ctl_t E_FW   = '{4'd0,  3'd0, 2'd0, 2'd0, 8'b00001000, 1'b0};
    localparam ctl_t E_FR   = '{4'd0,  3'd1, 2'd1, 2'd2, 8'b01101000, 1'b0};
    localparam ctl_t E_DEC  = '{4'd1,  3'd1, 2'd1, 2'd1, 8'b00000000, 1'b0};
    localparam ctl_t E_RADD = '{4'd2,  3'd1, 2'd0, 2'd0, 8'b00000000, 1'b0};
    localparam ctl_t E_RSUB = '{4'd2,  3'd2, 2'd0, 2'd0, 8'b00000000, 1'b0};
    localparam ctl_t E_RAND = '{4'd2,  3'd3, 2'd0, 2'd0, 8'b00000000, 1'b0};
    localparam ctl_t E_EI   = '{4'd3,  3'd1, 2'd0, 2'd1, 8'b00000000, 1'b0};
    localparam ctl_t E_AWB  = '{4'd4,  3'd0, 2'd0, 2'd0, 8'b00000010, 1'b0};
    localparam ctl_t E_MA   = '{4'd5,  3'd1, 2'd0, 2'd1, 8'b00000000, 1'b0};
    localparam ctl_t E_MRD  = '{4'd6,  3'd0, 2'd0, 2'd0, 8'b00011000, 1'b0};
    localparam ctl_t E_MWB  = '{4'd7,  3'd0, 2'd0, 2'd0, 8'b00000011, 1'b0};
    localparam ctl_t E_MWR  = '{4'd8,  3'd0, 2'd0, 2'd0, 8'b00010100, 1'b0};
    localparam ctl_t E_BRT  = '{4'd9,  3'd2, 2'd0, 2'd0, 8'b11000000, 1'b0};
    localparam ctl_t E_BRN  = '{4'd9,  3'd2, 2'd0, 2'd0, 8'b10000000, 1'b0};
    localparam ctl_t E_JMP  = '{4'd10, 3'd0, 2'd0, 2'd0, 8'b11000000, 1'b0};
    localparam ctl_t E_HLT  = '{4'd11, 3'd0, 2'd0, 2'd0, 8'b00000000, 1'b1};

    logic        clk = 1'b0;
    logic        reset, zero, neg, rdy;
    logic [3:0]  opcode;
    logic [2:0]  alu, alu2;
    logic [1:0]  sa, sb, sa2, sb2;
    logic        pcsrc, pcw, irw, iord, mr, mw, rw, m2r, halted;
    logic        pcsrc2, pcw2, irw2, iord2, mr2, mw2, rw2, m2r2, halted2;
    logic [3:0]  st, st2;
    logic [15:0] cnt, cnt2;
    ctl_t        got;
    exp_t        exp_q[$];
    string       name_q[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .input_opcode(opcode), .input_Zero(zero),
        .input_negative(neg), .input_mem_ready(rdy),
        .output_ALUOp(alu), .output_ALUSrcA(sa), .output_ALUSrcB(sb), .output_PCSrc(pcsrc),
        .output_PCWrite(pcw), .output_IRWrite(irw), .output_IorD(iord), .output_MemRead(mr),
        .output_MemWrite(mw), .output_RegWrite(rw), .output_MemToReg(m2r),
        .output_halted(halted), .output_state(st), .output_instr_count(cnt)
    );

    multicycle_controller #(.WAIT_LIMIT(4)) dut_lim (
        .clk(clk), .reset(reset), .input_opcode(opcode), .input_Zero(zero),
        .input_negative(neg), .input_mem_ready(rdy),
        .output_ALUOp(alu2), .output_ALUSrcA(sa2), .output_ALUSrcB(sb2), .output_PCSrc(pcsrc2),
        .output_PCWrite(pcw2), .output_IRWrite(irw2), .output_IorD(iord2), .output_MemRead(mr2),
        .output_MemWrite(mw2), .output_RegWrite(rw2), .output_MemToReg(m2r2),
        .output_halted(halted2), .output_state(st2), .output_instr_count(cnt2)
    );

    assign got = {st, alu, sa, sb, pcsrc, pcw, irw, iord, mr, mw, rw, m2r, halted};

    task automatic cyc(input string nm, input logic rn, input logic [3:0] op, input logic z,
                       input logic n, input logic r, input ctl_t c, input logic [15:0] ec,
                       input logic [3:0] es2);
        @(posedge clk);
        #1;
        reset = rn; opcode = op; zero = z; neg = n; rdy = r;
        exp_q.push_back(exp_t'{c, ec, es2});
        name_q.push_back(nm);
    endtask

    task automatic cy(input string nm, input logic rn, input logic [3:0] op, input logic z,
                      input logic n, input logic r, input ctl_t c, input logic [15:0] ec);
        cyc(nm, rn, op, z, n, r, c, ec, c.st);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if ({got, cnt} !== {e.c, e.cnt}) begin
                errors++;
                $display("FAIL %s: got st=%0d alu=%0d sa=%0d sb=%0d f=%b h=%b cnt=%0d, want st=%0d alu=%0d sa=%0d sb=%0d f=%b h=%b cnt=%0d",
                         nm, got.st, got.alu, got.sa, got.sb, got.f, got.h, cnt,
                         e.c.st, e.c.alu, e.c.sa, e.c.sb, e.c.f, e.c.h, e.cnt);
            end
            checks++;
            if (st2 !== e.st2) begin
                errors++;
                $display("FAIL %s_lim: got state=%0d, want state=%0d", nm, st2, e.st2);
            end
        end
    end

    initial begin
        reset = 1'b0; opcode = 4'h0; zero = 1'b0; neg = 1'b0; rdy = 1'b1;
        cy("rst0", 0, 4'h0, 0, 0, 1, E_RST, 0);
        cy("rst1", 0, 4'h0, 0, 0, 1, E_RST, 0);
        cy("add_f",  1, 4'h0, 0, 0, 1, E_FR,   0);
        cy("add_d",  1, 4'h0, 0, 0, 1, E_DEC,  0);
        cy("add_ex", 1, 4'h0, 0, 0, 1, E_RADD, 0);
        cy("add_wb", 1, 4'h0, 0, 0, 1, E_AWB,  0);
        cy("and_f",  1, 4'h2, 0, 0, 1, E_FR,   1);
        cy("and_d",  1, 4'h2, 0, 0, 1, E_DEC,  1);
        cy("and_ex", 1, 4'h2, 0, 0, 1, E_RAND, 1);
        cy("and_wb", 1, 4'h2, 0, 0, 1, E_AWB,  1);
        cy("addi_f",  1, 4'h4, 0, 0, 1, E_FR,  2);
        cy("addi_d",  1, 4'h4, 0, 0, 1, E_DEC, 2);
        cy("addi_ex", 1, 4'h4, 0, 0, 1, E_EI,  2);
        cy("addi_wb", 1, 4'h4, 0, 0, 1, E_AWB, 2);
        cy("lw_f",  1, 4'h5, 0, 0, 1, E_FR,  3);
        cy("lw_d",  1, 4'h5, 0, 0, 1, E_DEC, 3);
        cy("lw_ma", 1, 4'h5, 0, 0, 1, E_MA,  3);
        for (int i = 0; i < 3; i++) cy("lw_rd_wait", 1, 4'h5, 0, 0, 0, E_MRD, 3);
        cy("lw_rd_rdy", 1, 4'h5, 0, 0, 1, E_MRD, 3);
        cy("lw_wb",     1, 4'h5, 0, 0, 1, E_MWB, 3);
        cy("sw_f",  1, 4'h6, 0, 0, 1, E_FR,  4);
        cy("sw_d",  1, 4'h6, 0, 0, 1, E_DEC, 4);
        cy("sw_ma", 1, 4'h6, 0, 0, 1, E_MA,  4);
        cy("sw_wr", 1, 4'h6, 0, 0, 1, E_MWR, 4);
        cy("beq1_f",  1, 4'h7, 0, 0, 1, E_FR,  5);
        cy("beq1_d",  1, 4'h7, 0, 0, 1, E_DEC, 5);
        cy("beq1_br", 1, 4'h7, 1, 0, 1, E_BRT, 5);
        cy("beq0_f",  1, 4'h7, 0, 0, 1, E_FR,  6);
        cy("beq0_d",  1, 4'h7, 0, 0, 1, E_DEC, 6);
        cy("beq0_br", 1, 4'h7, 0, 1, 1, E_BRN, 6);
        cy("blt1_f",  1, 4'h8, 0, 0, 1, E_FR,  7);
        cy("blt1_d",  1, 4'h8, 0, 0, 1, E_DEC, 7);
        cy("blt1_br", 1, 4'h8, 0, 1, 1, E_BRT, 7);
        cy("blt0_f",  1, 4'h8, 0, 0, 1, E_FR,  8);
        cy("blt0_d",  1, 4'h8, 0, 0, 1, E_DEC, 8);
        cy("blt0_br", 1, 4'h8, 1, 0, 1, E_BRN, 8);
        cy("jmp_f", 1, 4'h9, 0, 0, 1, E_FR,  9);
        cy("jmp_d", 1, 4'h9, 0, 0, 1, E_DEC, 9);
        cy("jmp_j", 1, 4'h9, 0, 0, 1, E_JMP, 9);
        cy("ill_f", 1, 4'hC, 0, 0, 1, E_FR,  10);
        cy("ill_d", 1, 4'hC, 0, 0, 1, E_DEC, 10);
        for (int i = 0; i < 2; i++) cy("sub_fwait", 1, 4'h1, 0, 0, 0, E_FW, 11);
        cy("sub_f",  1, 4'h1, 0, 0, 1, E_FR,   11);
        cy("sub_d",  1, 4'h1, 0, 0, 1, E_DEC,  11);
        cy("sub_ex", 1, 4'h1, 0, 0, 1, E_RSUB, 11);
        cy("sub_wb", 1, 4'h1, 0, 0, 1, E_AWB,  11);
        cy("hlt_f", 1, 4'hF, 0, 0, 1, E_FR,  12);
        cy("hlt_d", 1, 4'hF, 0, 0, 1, E_DEC, 12);
        for (int i = 0; i < 20; i++) cy("halted", 1, 4'hF, i[0], i[1], i[0], E_HLT, 12);
        cy("hlt_rst",   0, 4'hF, 0, 0, 1, E_RST, 0);
        cy("post_rst",  1, 4'h6, 0, 0, 1, E_FR,  0);
        cy("sw2_d",     1, 4'h6, 0, 0, 1, E_DEC, 0);
        cy("sw2_ma",    1, 4'h6, 0, 0, 1, E_MA,  0);
        cy("sw2_wait",  1, 4'h6, 0, 0, 0, E_MWR, 0);
        cy("sw2_rst",   0, 4'h6, 0, 0, 0, E_RST, 0);
        for (int i = 0; i < 4; i++) cyc("to_wait", 1, 4'h0, 0, 0, 0, E_FW, 0, 4'd0);
        for (int i = 0; i < 2; i++) cyc("to_halt", 1, 4'h0, 0, 0, 0, E_FW, 0, 4'd11);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
